// File: rtl/me_stage_ctrl.sv
// Memory-access pipeline stage controller: issues word loads/stores over a req/ack
// handshake, stalls upstream while an access is outstanding, and holds the ME->WB register.
module me_stage_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_0,
  input  logic [31:0] ans_me,
  input  logic [31:0] b_me,
  input  logic [4:0]  rw_me,
  input  logic        wreg_me,
  input  logic        m2reg_me,
  input  logic        wmem_me,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [31:0] result_wb,
  output logic [4:0]  rw_wb,
  output logic        wreg_wb,
  output logic        err
);

  // state    | meaning
  // S_IDLE   | decode the EX->ME op; ALU ops and faults retire here in one cycle
  // S_ACCESS | request outstanding, waiting for mem_ack or the timeout
  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_result_wb;
  logic [4:0]  r_rw_wb;
  logic        r_wreg_wb;
  logic        r_err;

  logic w_mem_op;
  logic w_bad;
  logic w_tmo;
  logic w_stall;

  assign w_mem_op = wmem_me ^ m2reg_me;
  assign w_bad    = (wmem_me & m2reg_me) | (w_mem_op & (ans_me[1:0] != 2'b00));
  assign w_tmo    = (MEM_TIMEOUT != 0) && (r_cnt == 16'(MEM_TIMEOUT - 1));

  // Stall drops in the ack/abort cycle so upstream advances on the same edge.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:   w_stall = w_mem_op & ~w_bad;
      S_ACCESS: w_stall = ~mem_ack & ~w_tmo;
      default:  w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_result_wb <= 32'd0;
      r_rw_wb     <= 5'd0;
      r_wreg_wb   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_bad) begin
            r_err       <= 1'b1;
            r_result_wb <= ans_me;
            r_rw_wb     <= rw_me;
            r_wreg_wb   <= 1'b0;
          end else if (w_mem_op) begin
            r_state     <= S_ACCESS;
            r_mem_req   <= 1'b1;
            r_mem_we    <= wmem_me;
            r_mem_addr  <= ans_me;
            r_mem_wdata <= b_me;
            r_wreg_wb   <= 1'b0;
            r_cnt       <= 16'd0;
          end else begin
            r_result_wb <= ans_me;
            r_rw_wb     <= rw_me;
            r_wreg_wb   <= wreg_me;
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_result_wb <= m2reg_me ? mem_rdata : ans_me;
            r_rw_wb     <= rw_me;
            r_wreg_wb   <= wreg_me;
          end else if (w_tmo) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_wreg_wb <= 1'b0;
          end else begin
            r_wreg_wb <= 1'b0;
            r_cnt     <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign stall     = w_stall & reset_0;
  assign result_wb = r_result_wb;
  assign rw_wb     = r_rw_wb;
  assign wreg_wb   = r_wreg_wb;
  assign err       = r_err;

endmodule

// File: tb/tb_me_stage_ctrl.sv
// Directed bench for me_stage_ctrl: ALU, load, store, faults, timeout and reset cases.
module tb_me_stage_ctrl;

  logic        clock = 1'b0;
  logic        reset_0 = 1'b0;
  logic [31:0] ans_me = '0;
  logic [31:0] b_me = '0;
  logic [4:0]  rw_me = '0;
  logic        wreg_me = 1'b0;
  logic        m2reg_me = 1'b0;
  logic        wmem_me = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall;
  logic [31:0] result_wb;
  logic [4:0]  rw_wb;
  logic        wreg_wb;
  logic        err;

  int errors = 0;
  int checks = 0;

  me_stage_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset_0(reset_0), .ans_me(ans_me), .b_me(b_me), .rw_me(rw_me),
    .wreg_me(wreg_me), .m2reg_me(m2reg_me), .wmem_me(wmem_me), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall(stall), .result_wb(result_wb), .rw_wb(rw_wb),
    .wreg_wb(wreg_wb), .err(err)
  );

  always #5 clock = ~clock;

  // Inputs change right after a falling edge; everything is sampled 1 time unit later.
  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rw,
                        input logic wr, input logic ld, input logic st);
    ans_me = a; b_me = b; rw_me = rw; wreg_me = wr; m2reg_me = ld; wmem_me = st;
  endtask

  task automatic next_cycle;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset_0 = 1'b0;
    set_op(32'h100, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    next_cycle(); #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h expected all 0", mem_req, mem_we, mem_addr, mem_wdata); end
    checks++; if (result_wb !== 32'h0 || rw_wb !== 5'd0 || wreg_wb !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_wb: result=%h rw=%0d wreg=%b err=%b expected all 0", result_wb, rw_wb, wreg_wb, err); end
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset_0 = 1'b1;
    next_cycle();
  endtask

  task automatic test_alu;
    int nstall = 0;
    set_op(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    #1; if (stall) nstall++;
    next_cycle(); #1;
    checks++; if (result_wb !== 32'h1234 || rw_wb !== 5'd5 || wreg_wb !== 1'b1) begin
      errors++; $display("FAIL alu_wb: result=%h rw=%0d wreg=%b expected 1234/5/1", result_wb, rw_wb, wreg_wb); end
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1; if (stall) nstall++;
    checks++; if (nstall !== 0) begin errors++; $display("FAIL alu_stall: got %0d stall cycles expected 0", nstall); end
    next_cycle();
  endtask

  task automatic test_load;
    int nstall = 0;
    int nwreg = 0;
    set_op(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
      #1;
      if (stall) nstall++;
      if (i >= 1) begin
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || wreg_wb !== 1'b0) begin
          errors++; $display("FAIL load_access[%0d]: req=%b we=%b addr=%h wreg=%b expected 1/0/100/0", i, mem_req, mem_we, mem_addr, wreg_wb); end
      end
      next_cycle();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (nstall !== 4) begin errors++; $display("FAIL load_stall: got %0d stall cycles expected 4", nstall); end
    checks++; if (result_wb !== 32'hDEADBEEF || rw_wb !== 5'd7 || mem_req !== 1'b0) begin
      errors++; $display("FAIL load_wb: result=%h rw=%0d req=%b expected deadbeef/7/0", result_wb, rw_wb, mem_req); end
    if (wreg_wb) nwreg++;
    next_cycle(); #1;
    if (wreg_wb) nwreg++;
    checks++; if (nwreg !== 1) begin errors++; $display("FAIL load_wreg_once: got %0d expected 1", nwreg); end
    next_cycle();
  endtask

  task automatic test_store;
    int nstall = 0;
    set_op(32'h40, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1);
    #1; if (stall) nstall++;
    next_cycle();
    mem_ack = 1'b1;
    #1; if (stall) nstall++;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL store_access: req=%b we=%b addr=%h wdata=%h expected 1/1/40/a5a5a5a5", mem_req, mem_we, mem_addr, mem_wdata); end
    next_cycle();
    mem_ack = 1'b0;
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (nstall !== 1) begin errors++; $display("FAIL store_stall: got %0d expected 1", nstall); end
    checks++; if (mem_req !== 1'b0 || wreg_wb !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL store_done: req=%b wreg=%b err=%b expected 0/0/0", mem_req, wreg_wb, err); end
    next_cycle();
  endtask

  task automatic test_faults;
    int nreq = 0;
    set_op(32'h102, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL misalign_stall: got %b expected 0", stall); end
    next_cycle();
    set_op(32'h200, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1);
    #1; if (mem_req) nreq++;
    checks++; if (err !== 1'b1 || wreg_wb !== 1'b0 || result_wb !== 32'h102 || rw_wb !== 5'd3) begin
      errors++; $display("FAIL misalign_err: err=%b wreg=%b result=%h rw=%0d expected 1/0/102/3", err, wreg_wb, result_wb, rw_wb); end
    next_cycle();
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1; if (mem_req) nreq++;
    checks++; if (err !== 1'b1 || wreg_wb !== 1'b0) begin
      errors++; $display("FAIL illegal_err: err=%b wreg=%b expected 1/0", err, wreg_wb); end
    next_cycle(); #1; if (mem_req) nreq++;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b expected 0", err); end
    checks++; if (nreq !== 0) begin errors++; $display("FAIL fault_req: got %0d req cycles expected 0", nreq); end
    next_cycle();
  endtask

  task automatic test_timeout;
    int nreq = 0;
    set_op(32'h80, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL tmo_issue_stall: got %b expected 1", stall); end
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); #1;
      if (mem_req) nreq++;
      checks++; if (stall !== (i < 4) || err !== 1'b0) begin
        errors++; $display("FAIL tmo_wait[%0d]: stall=%b err=%b expected %b/0", i, stall, err, (i < 4)); end
    end
    next_cycle();
    set_op(32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (nreq !== 4) begin errors++; $display("FAIL tmo_req_cycles: got %0d expected 4", nreq); end
    checks++; if (mem_req !== 1'b0 || err !== 1'b1 || stall !== 1'b0 || wreg_wb !== 1'b0) begin
      errors++; $display("FAIL tmo_abort: req=%b err=%b stall=%b wreg=%b expected 0/1/0/0", mem_req, err, stall, wreg_wb); end
    next_cycle();
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (result_wb !== 32'h55 || rw_wb !== 5'd9 || wreg_wb !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL tmo_next_op: result=%h rw=%0d wreg=%b err=%b expected 55/9/1/0", result_wb, rw_wb, wreg_wb, err); end
    next_cycle();
  endtask

  task automatic test_reset_mid_access;
    set_op(32'h300, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
    next_cycle(); #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_up: got %b expected 1", mem_req); end
    #1 reset_0 = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || wreg_wb !== 1'b0) begin
      errors++; $display("FAIL mid_reset: req=%b stall=%b wreg=%b expected 0/0/0", mem_req, stall, wreg_wb); end
    next_cycle();
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset_0 = 1'b1;
    next_cycle();
  endtask

  task automatic test_back_to_back;
    set_op(32'h10, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0);
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    #1;
    checks++; if (stall !== 1'b0 || mem_addr !== 32'h10) begin
      errors++; $display("FAIL b2b_a_ack: stall=%b addr=%h expected 0/10", stall, mem_addr); end
    next_cycle();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    set_op(32'h14, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (result_wb !== 32'h11111111 || rw_wb !== 5'd1 || wreg_wb !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL b2b_a_wb: result=%h rw=%0d wreg=%b stall=%b expected 11111111/1/1/1", result_wb, rw_wb, wreg_wb, stall); end
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'h22222222;
    #1;
    checks++; if (mem_addr !== 32'h14 || wreg_wb !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL b2b_b_ack: addr=%h wreg=%b stall=%b expected 14/0/0", mem_addr, wreg_wb, stall); end
    next_cycle();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (result_wb !== 32'h22222222 || rw_wb !== 5'd2 || wreg_wb !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_b_wb: result=%h rw=%0d wreg=%b req=%b expected 22222222/2/1/0", result_wb, rw_wb, wreg_wb, mem_req); end
    next_cycle();
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_faults();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
